// File: rtl/spi_master_ss.sv
// spi_master_ss: 16-bit SPI master, mode 0 (CPOL=0, CPHA=0), with a built-in
// slave-select decoder for the three trigger DAC/AFE channels, a spare, and
// the calibration EEPROM. One transaction: front porch, 16 SCLK periods,
// back porch, then a single-cycle done pulse with the received word.
module spi_master_ss #(
   parameter int SCLK_DIV = 32   // system clocks per SCLK period, even and >= 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] cmd,
   input  logic [2:0]  ss,
   input  logic        MISO,
   output logic        SCLK,
   output logic        MOSI,
   output logic [4:0]  SS_n,
   output logic        busy,
   output logic        done,
   output logic [15:0] rd_data
);

   localparam int HALF = SCLK_DIV / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      PORCH_F,
      SHIFT,
      PORCH_B
   } state_t;

   // Everything except the FSM state that lives in a flop. SCLK, MOSI and
   // SS_n are all registered so the pins never glitch.
   typedef struct packed {
      logic [CW-1:0] hcnt;   // half-period counter
      logic [3:0]    bcnt;   // completed SCLK periods (falling edges)
      logic [15:0]   shreg;  // outgoing command / incoming response
      logic          sclk;
      logic          mosi;
      logic [4:0]    ss_n;
      logic          busy;
      logic          done;
      logic [15:0]   rd;
   } regs_t;

   localparam regs_t REGS_RESET = '{
      hcnt:  '0,
      bcnt:  '0,
      shreg: '0,
      sclk:  1'b0,
      mosi:  1'b0,
      ss_n:  5'b11111,
      busy:  1'b0,
      done:  1'b0,
      rd:    '0
   };

   state_t state, state_nxt;
   regs_t  r, r_nxt;
   logic   hc_tc;

   // Indices 0..4 pull one select low; 5..7 select nothing but the frame
   // still runs so the upstream sequencer always gets its done.
   function automatic logic [4:0] ss_decode(input logic [2:0] idx);
      logic [4:0] sel;
      sel = 5'b11111;
      if (idx < 3'd5) sel[idx] = 1'b0;
      return sel;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge values; blocking here would create ordering races.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r <= REGS_RESET;
      else        r <= r_nxt;
   end

   // Next-state and next-register logic for the whole transaction.
   always_comb begin
      // NOTE: every target gets a default before the case so no path leaves
      // it unassigned; a missing default here infers a latch.
      state_nxt = state;
      r_nxt     = r;
      r_nxt.done = 1'b0;
      hc_tc     = (r.hcnt == HALF_TC);

      case (state)
         IDLE: begin
            if (wrt) begin
               state_nxt   = PORCH_F;
               r_nxt.shreg = cmd;
               r_nxt.mosi  = cmd[15];
               r_nxt.ss_n  = ss_decode(ss);
               r_nxt.busy  = 1'b1;
               r_nxt.sclk  = 1'b0;
               r_nxt.hcnt  = '0;
               r_nxt.bcnt  = '0;
            end
         end

         // Select asserted, first data bit on MOSI, SCLK held low.
         PORCH_F: begin
            if (hc_tc) begin
               r_nxt.hcnt = '0;
               state_nxt  = SHIFT;
            end else begin
               r_nxt.hcnt = r.hcnt + 1'b1;
            end
         end

         // Each terminal count toggles SCLK; low half first, then high.
         SHIFT: begin
            if (hc_tc) begin
               r_nxt.hcnt = '0;
               r_nxt.sclk = ~r.sclk;
               if (!r.sclk) begin
                  // Rising edge: capture MISO; MOSI is left alone so it
                  // only ever moves while SCLK is low.
                  r_nxt.shreg = {r.shreg[14:0], MISO};
               end else begin
                  // Falling edge: one bit period complete.
                  r_nxt.bcnt = r.bcnt + 1'b1;
                  if (r.bcnt == 4'd15) begin
                     r_nxt.mosi = 1'b0;
                     state_nxt  = PORCH_B;
                  end else begin
                     r_nxt.mosi = r.shreg[15];
                  end
               end
            end else begin
               r_nxt.hcnt = r.hcnt + 1'b1;
            end
         end

         // Hold select with SCLK low, then release and report.
         PORCH_B: begin
            if (hc_tc) begin
               r_nxt.hcnt = '0;
               r_nxt.ss_n = 5'b11111;
               r_nxt.busy = 1'b0;
               r_nxt.done = 1'b1;
               r_nxt.rd   = r.shreg;
               state_nxt  = IDLE;
            end else begin
               r_nxt.hcnt = r.hcnt + 1'b1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign SCLK    = r.sclk;
   assign MOSI    = r.mosi;
   assign SS_n    = r.ss_n;
   assign busy    = r.busy;
   assign done    = r.done;
   assign rd_data = r.rd;

endmodule

// File: doc/spi_master_ss.md
Name: spi_master_ss

Overview:
- 16-bit SPI master, mode 0 (CPOL=0, CPHA=0), with an integrated slave-select decoder.
- Sits directly downstream of the command/config block. It consumes that block's SPI_data, wrt_SPI and ss, and returns SPI_done and the low read byte (EEP_data).
- Drives five active-low slave selects:
  - trigger-level DAC / AFE channels 0..2 on ss 0..2,
  - spare on ss 3,
  - calibration EEPROM on ss 4.

Parameters:
- SCLK_DIV, 32, system clocks per SCLK period. Must be even and >= 4. HALF = SCLK_DIV/2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wrt  input  1  start-transaction strobe (connects to wrt_SPI)
- cmd  input  16  word to transmit, MSB first (connects to SPI_data)
- ss  input  3  slave index, sampled with wrt
- MISO  input  1  serial data from slave
- SCLK  output  1  serial clock, idle low
- MOSI  output  1  serial data to slave
- SS_n  output  5  active-low one-hot slave selects
- busy  output  1  high from the cycle after an accepted wrt until done
- done  output  1  one-cycle pulse at transaction end (connects to SPI_done)
- rd_data  output  16  word shifted in from MISO; rd_data[7:0] is EEP_data

Behaviour:
- Reset values: SCLK=0, MOSI=0, SS_n=5'b11111, busy=0, done=0, rd_data=16'h0000, state=IDLE.
- FSM states: IDLE, PORCH_F, SHIFT, PORCH_B.
- IDLE:
  - wrt=1: latch cmd into shift register, latch ss, clear the half-period counter and bit counter, go to PORCH_F.
  - The next cycle: busy=1, the selected SS_n bit=0, MOSI=cmd[15].
- ss decode: values 0..4 drive SS_n[ss] low. Values 5..7 assert no select; the transaction still runs in full and done still pulses.
- PORCH_F:
  - SCLK stays low for HALF clocks, then go to SHIFT.
- SHIFT, 16 SCLK periods:
  - Each half-period counter terminal count toggles SCLK.
  - On the cycle SCLK rises: sample MISO into shift register LSB. The shift register shifts left once per bit.
  - On the cycle SCLK falls: MOSI presents the next bit.
  - Bit counter increments on each falling edge. After the 16th falling edge, go to PORCH_B.
- PORCH_B:
  - SCLK low for HALF clocks.
  - Then, in one cycle: SS_n all high, busy=0, done=1, rd_data loaded with the shift-register contents; return to IDLE.
- Latency: done asserts exactly HALF + 16*SCLK_DIV + HALF clocks after the wrt cycle, i.e. 544 clocks for the default.
- rd_data holds its value until the next done. It is not disturbed during a transaction.
- wrt while busy=1 is ignored: no relatch, and cmd/ss changes have no effect.
- wrt in the same cycle as done (FSM in IDLE next cycle): not accepted. wrt is accepted only when the FSM is in IDLE.
- Back-to-back: a wrt in the first IDLE cycle after done starts a new transaction. SS_n is high for at least 1 clock between transactions.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). No done pulse; the partial rd_data is discarded.
- MOSI changes only while SCLK is low. SCLK is glitch-free and driven from a flop.

Test Plan:
- Reset with rst_n=0 -> SCLK=0, SS_n=5'b11111, done=0, rd_data=0, busy=0.
- wrt, cmd=16'h1380, ss=0, slave model returns 16'hA55A on MISO -> SS_n=5'b11110 during the transaction, MOSI bit stream 0001_0011_1000_0000, exactly 16 SCLK rising edges, done pulse 544 clocks after wrt, rd_data=16'hA55A.
- EEPROM read: wrt, cmd=16'h0A00, ss=4, slave returns 16'h00C3 -> SS_n=5'b01111, rd_data[7:0]=8'hC3, done width exactly 1 clock.
- During busy, pulse wrt with cmd=16'hFFFF, ss=1 -> ignored: MOSI stream and SS_n unchanged, a single done pulse.
- ss=7 -> SS_n stays 5'b11111 throughout, 16 SCLK edges still generated, done pulses at 544 clocks.
- Assert rst_n=0 after bit 8 -> SS_n=5'b11111 and SCLK=0 in the same cycle, no done. A following transaction with cmd=16'h5555 completes normally with correct rd_data.
